// File: rtl/uartin_pkg.sv
// rtl/uartin_pkg.sv - shared UART constants, active-low levels and receiver state type
package uartin_pkg;

    localparam logic nT = 1'b0;
    localparam logic nF = 1'b1;

    localparam int   UART_NBITS      = 8;
    localparam logic UART_STOP_LEVEL = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_rx_state_t;

endpackage

// File: rtl/uartin_if.sv
// rtl/uartin_if.sv - active-low valid_n/ready_n byte handshake between receiver and consumer
interface uartin_if;
    import uartin_pkg::*;

    logic [UART_NBITS-1:0] data;
    logic                  valid_n;
    logic                  ready_n;

    modport master (output data, output valid_n, input ready_n);
    modport slave  (input data, input valid_n, output ready_n);

endinterface

// File: rtl/uartin_sync_ff.sv
// rtl/uartin_sync_ff.sv - multi-flop synchroniser for asynchronous pins, resets to 1
module sync_ff #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [N-1:0] chain_q;
    logic [N-1:0] chain_d;

    // Shift the raw pin value one stage further down the chain each clock
    always_comb begin
        chain_d = {chain_q[N-2:0], d};
    end

    // Chain register; resets to the idle-high line level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_q <= '1;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q = chain_q[N-1];

endmodule

// File: rtl/uartin.sv
// rtl/uartin.sv - 8N1 UART receiver with oversampled bit timing and held output byte
module uartin
    import uartin_pkg::*;
#(
    parameter int CDIV  = 2,
    parameter int NSYNC = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rx,
    uartin_if.master  out_if,
    output logic      frame_err,
    output logic      overrun,
    output logic      busy
);

    localparam int HALF = CDIV / 2;
    localparam int DW   = $clog2(CDIV);
    localparam int IW   = $clog2(UART_NBITS);

    localparam logic [DW-1:0] DIV_HALF = DW'(HALF - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CDIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(UART_NBITS - 1);

    logic rx_s;

    uart_rx_state_t        state_q, state_d;
    logic [DW-1:0]         div_q, div_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [UART_NBITS-1:0] shift_q, shift_d;
    logic                  armed_q, armed_d;
    logic [UART_NBITS-1:0] data_q, data_d;
    logic                  valid_n_q, valid_n_d;
    logic                  frame_err_q, frame_err_d;
    logic                  overrun_q, overrun_d;
    logic                  byte_done;
    logic                  stop_bad;
    logic                  xfer;

    sync_ff #(.N(NSYNC)) u_rx_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    // Frame sequencing: start-bit qualification, mid-bit data sampling, stop check.
    // armed_q blocks a new START after a bad stop bit until the line returns high,
    // so a held break is not mistaken for another frame.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        armed_d   = armed_q;
        byte_done = 1'b0;
        stop_bad  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!armed_q) begin
                    if (rx_s == UART_STOP_LEVEL) armed_d = 1'b1;
                end else if (rx_s == 1'b0) begin
                    state_d = START;
                    div_d   = '0;
                end
            end
            START: begin
                if (div_q == DIV_HALF) begin
                    div_d = '0;
                    if (rx_s == 1'b0) begin
                        state_d = DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            DATA: begin
                if (div_q == DIV_LAST) begin
                    div_d          = '0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == IDX_LAST) state_d = STOP;
                    else                   idx_d   = idx_q + 1'b1;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            STOP: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    state_d = IDLE;
                    if (rx_s == UART_STOP_LEVEL) begin
                        byte_done = 1'b1;
                    end else begin
                        stop_bad = 1'b1;
                        armed_d  = 1'b0;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output holding register: load on completion when empty or being drained,
    // otherwise keep the old byte and flag the loss
    always_comb begin
        xfer        = (valid_n_q == nT) && (out_if.ready_n == nT);
        data_d      = data_q;
        valid_n_d   = valid_n_q;
        overrun_d   = 1'b0;
        frame_err_d = stop_bad;
        if (byte_done) begin
            if ((valid_n_q == nF) || xfer) begin
                data_d    = shift_q;
                valid_n_d = nT;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (xfer) begin
            valid_n_d = nF;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            div_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            armed_q     <= 1'b1;
            data_q      <= '0;
            valid_n_q   <= nF;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            armed_q     <= armed_d;
            data_q      <= data_d;
            valid_n_q   <= valid_n_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_if.data    = data_q;
    assign out_if.valid_n = valid_n_q;
    assign frame_err      = frame_err_q;
    assign overrun        = overrun_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_uartin.sv
// tb/tb_uartin.sv - self-checking bench for uartin with a byte-queue reference model
module tb_uartin;
    import uartin_pkg::*;

    localparam int CDIV  = 4;
    localparam int NSYNC = 2;
    localparam int HALF  = CDIV / 2;
    localparam int LAT   = NSYNC + HALF + 9 * CDIV;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    logic frame_err, overrun, busy;

    uartin_if bus ();

    uartin #(.CDIV(CDIV), .NSYNC(NSYNC)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .out_if    (bus.master),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    logic [7:0] exp_q[$];
    int         start_q[$];
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    bit         busy_seen = 0;
    logic       prev_valid_n = 1'b1;
    logic [7:0] prev_data = 8'h00;
    logic       prev_xfer = 1'b0;
    bit         lat_ok;
    logic [7:0] rb;
    int         gap;
    int         hi;
    bit         done;

    // Compare process: byte order, hold stability, arrival latency, pulse rules
    always @(negedge clk) begin
        if (rst) begin
            prev_valid_n = 1'b1;
            prev_xfer    = 1'b0;
        end else begin
            if (frame_err) fe_cnt++;
            if (overrun)   ov_cnt++;
            if (busy)      busy_seen = 1'b1;
            if (frame_err || overrun)
                chk("pulse_exclusive", {31'b0, frame_err & overrun}, 32'd0);
            if (bus.valid_n == 1'b0 && prev_valid_n == 1'b0 && !prev_xfer)
                chk("data_hold", {24'b0, bus.data}, {24'b0, prev_data});
            if (bus.valid_n == 1'b0 && prev_valid_n == 1'b1) begin
                lat_ok = 1'b0;
                foreach (start_q[i])
                    if ((cyc - start_q[i] >= LAT - 1) && (cyc - start_q[i] <= LAT + 1)) lat_ok = 1'b1;
                chk("latency", {31'b0, lat_ok}, 32'd1);
            end
            if (bus.valid_n == 1'b0 && bus.ready_n == 1'b0) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got %0h expected none", bus.data);
                end else begin
                    chk("rx_byte", {24'b0, bus.data}, {24'b0, exp_q.pop_front()});
                end
            end
            prev_valid_n = bus.valid_n;
            prev_data    = bus.data;
            prev_xfer    = (bus.valid_n == 1'b0) && (bus.ready_n == 1'b0);
        end
    end

    task automatic drive(input logic v, input int n);
        rx = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        drive(1'b1, n);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_lvl, input int stop_len);
        start_q.push_back(cyc);
        if (start_q.size() > 4) void'(start_q.pop_front());
        drive(1'b0, CDIV);
        for (int i = 0; i < 8; i++) drive(b[i], CDIV);
        drive(stop_lvl, stop_len);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] xb;
        bus.ready_n = 1'b0;
        rx          = 1'b1;
        rst         = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(4);

        // reset pulse mid-idle
        rst = 1'b1;
        #1;
        chk("rst_valid_n", {31'b0, bus.valid_n}, 32'd1);
        chk("rst_data", {24'b0, bus.data}, 32'h00);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_frame_err", {31'b0, frame_err}, 32'd0);
        chk("rst_overrun", {31'b0, overrun}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(4);

        // "abc" with consumer always ready
        fe_cnt = 0;
        ov_cnt = 0;
        exp_q.push_back(8'h61);
        exp_q.push_back(8'h62);
        exp_q.push_back(8'h63);
        send_frame(8'h61, 1'b1, CDIV);
        send_frame(8'h62, 1'b1, CDIV);
        send_frame(8'h63, 1'b1, CDIV);
        idle(16);
        chk("abc_all_received", exp_q.size(), 32'd0);
        chk("abc_last_data", {24'b0, bus.data}, 32'h63);
        chk("abc_frame_err", fe_cnt, 32'd0);
        chk("abc_overrun", ov_cnt, 32'd0);

        // backpressure: second byte overruns
        bus.ready_n = 1'b1;
        ov_cnt      = 0;
        exp_q.push_back(8'h61);
        send_frame(8'h61, 1'b1, CDIV);
        send_frame(8'h62, 1'b1, CDIV);
        idle(16);
        chk("bp_overrun", ov_cnt, 32'd1);
        chk("bp_valid_n", {31'b0, bus.valid_n}, 32'd0);
        chk("bp_data", {24'b0, bus.data}, 32'h61);
        bus.ready_n = 1'b0;
        @(posedge clk);
        #1;
        bus.ready_n = 1'b1;
        chk("bp_drained_valid_n", {31'b0, bus.valid_n}, 32'd1);
        chk("bp_drained", exp_q.size(), 32'd0);
        bus.ready_n = 1'b0;
        idle(4);

        // glitch shorter than half a bit
        busy_seen = 1'b0;
        fe_cnt    = 0;
        drive(1'b0, HALF - 1);
        idle(16);
        chk("glitch_busy_seen", {31'b0, busy_seen}, 32'd1);
        chk("glitch_busy", {31'b0, busy}, 32'd0);
        chk("glitch_valid_n", {31'b0, bus.valid_n}, 32'd1);
        chk("glitch_frame_err", fe_cnt, 32'd0);

        // framing error with long break, then a good frame
        fe_cnt = 0;
        send_frame(8'h55, 1'b0, 2 * CDIV);
        idle(16);
        chk("ferr_pulses", fe_cnt, 32'd1);
        chk("ferr_valid_n", {31'b0, bus.valid_n}, 32'd1);
        exp_q.push_back(8'h41);
        send_frame(8'h41, 1'b1, CDIV);
        idle(16);
        chk("ferr_recover", exp_q.size(), 32'd0);
        chk("ferr_no_more", fe_cnt, 32'd1);

        // reset mid-frame drops the held byte and the partial one
        bus.ready_n = 1'b1;
        send_frame(8'h71, 1'b1, CDIV);
        idle(16);
        chk("held_valid_n", {31'b0, bus.valid_n}, 32'd0);
        chk("held_data", {24'b0, bus.data}, 32'h71);
        xb = 8'h78;
        drive(1'b0, CDIV);
        for (int i = 0; i < 3; i++) drive(xb[i], CDIV);
        rx = xb[3];
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_valid_n", {31'b0, bus.valid_n}, 32'd1);
        chk("midrst_data", {24'b0, bus.data}, 32'h00);
        #2;
        rx = 1'b1;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        bus.ready_n = 1'b0;
        idle(8);
        exp_q.push_back(8'h79);
        send_frame(8'h79, 1'b1, CDIV);
        idle(16);
        chk("midrst_next", exp_q.size(), 32'd0);

        // random bytes, gaps and consumer readiness
        fe_cnt = 0;
        ov_cnt = 0;
        done   = 1'b0;
        fork
            begin
                for (int k = 0; k < 24; k++) begin
                    rb  = 8'($urandom);
                    gap = $urandom_range(0, 2 * CDIV);
                    exp_q.push_back(rb);
                    send_frame(rb, 1'b1, CDIV);
                    if (gap > 0) idle(gap);
                end
                done = 1'b1;
            end
            begin
                hi = 0;
                while (!done) begin
                    @(posedge clk);
                    #1;
                    if (hi >= 12) bus.ready_n = 1'b0;
                    else          bus.ready_n = 1'($urandom_range(0, 1));
                    hi = bus.ready_n ? hi + 1 : 0;
                end
            end
        join
        bus.ready_n = 1'b0;
        idle(20);
        chk("rand_all_received", exp_q.size(), 32'd0);
        chk("rand_overrun", ov_cnt, 32'd0);
        chk("rand_frame_err", fe_cnt, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
